// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared constants and types for the serial memory-link responder.
// The header codes and start pattern are the same values the CPU side
// uses to build command frames.
// No ports (package).
package mem_responder_pkg;

    // Width of the command header field on the link.
    localparam int TX_CMD_BITS = 2;

    // Command header codes.
    localparam logic [1:0] TX_HEADER_READ_16  = 2'd0;
    localparam logic [1:0] TX_HEADER_WRITE_16 = 2'd1;
    localparam logic [1:0] TX_HEADER_READ_8   = 2'd2;
    localparam logic [1:0] TX_HEADER_WRITE_8  = 2'd3;

    // Start-of-frame pattern, in both directions.
    localparam int TX_START_PATTERN = 1;

    // Responder FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_DELAY  = 3'd4,
        ST_RSTART = 3'd5,
        ST_RDATA  = 3'd6
    } state_t;

    // Bit 0 of the code distinguishes writes from reads.
    function automatic logic cmd_is_write(input logic [1:0] cmd);
        return cmd[0];
    endfunction

    // Bit 1 of the code distinguishes 8-bit from 16-bit accesses.
    function automatic logic cmd_is_byte(input logic [1:0] cmd);
        return cmd[1];
    endfunction

    // Byte lanes touched by an access: both for 16-bit, one for 8-bit.
    function automatic logic [1:0] byte_enables(input logic is_byte, input logic addr_lsb);
        logic [1:0] be;
        if (is_byte) begin
            be = addr_lsb ? 2'b10 : 2'b01;
        end else begin
            be = 2'b11;
        end
        return be;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
// Link and backdoor signals between the CPU side (master) and the
// memory responder (slave).
//   rx_pins   : command stream CPU -> responder, all-zero when idle
//   tx_pins   : response stream responder -> CPU, all-zero when idle
//   busy      : responder is inside a frame or response
//   proto_err : sticky protocol-violation flag
//   init_we/init_addr/init_data : backdoor word write into the RAM
interface mem_responder_if #(
    parameter int IO_BITS       = 2,
    parameter int MEM_ADDR_BITS = 6
);
    logic [IO_BITS-1:0]       rx_pins;
    logic [IO_BITS-1:0]       tx_pins;
    logic                     busy;
    logic                     proto_err;
    logic                     init_we;
    logic [MEM_ADDR_BITS-1:0] init_addr;
    logic [15:0]              init_data;

    modport master (
        output rx_pins, init_we, init_addr, init_data,
        input  tx_pins, busy, proto_err
    );

    modport slave (
        input  rx_pins, init_we, init_addr, init_data,
        output tx_pins, busy, proto_err
    );
endinterface

// File: rtl/mem_responder_mem.sv
// responder_mem
// 2^ADDR_BITS x 16 word RAM with per-byte write enables, one synchronous
// write port and one asynchronous read port. Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_be    : byte enables, [1] high byte, [0] low byte
//   i_waddr : write word address
//   i_wdata : write data (both lanes presented; i_be selects)
//   i_raddr : read word address
//   o_rdata : read data, combinational from i_raddr
module responder_mem #(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [1:0]           i_be,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [15:0]          i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [15:0]          o_rdata
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [15:0] r_mem [DEPTH];

    // Byte-lane writes into the storage array.
    always_ff @(posedge clk) begin
        if (i_we && i_be[0]) begin
            r_mem[i_waddr][7:0] <= i_wdata[7:0];
        end
        if (i_we && i_be[1]) begin
            r_mem[i_waddr][15:8] <= i_wdata[15:8];
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory side of the serial CPU memory link. Deserialises command frames
// from rx_pins, executes them against a local word RAM and serialises read
// data back on tx_pins. One transaction at a time; LSB first.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : mem_responder_if.slave (rx_pins, tx_pins, busy, proto_err,
//           init_we, init_addr, init_data)
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int IO_BITS        = 2,
    parameter int PAYLOAD_CYCLES = 16 / IO_BITS,
    parameter int MEM_ADDR_BITS  = 6,
    parameter int RESP_DELAY     = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam logic [15:0] FULL_LAST = 16'(PAYLOAD_CYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(PAYLOAD_CYCLES / 2 - 1);
    // Clamped so the constant stays legal when the DELAY state is unused.
    localparam logic [15:0] DLY_LAST  = 16'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);
    localparam logic [IO_BITS-1:0] START_PAT = IO_BITS'(TX_START_PATTERN);
    localparam logic [IO_BITS-1:0] IDLE_PAT  = {IO_BITS{1'b0}};

    state_t                   r_state;
    logic [15:0]              r_cnt;
    logic [TX_CMD_BITS-1:0]   r_cmd;
    logic [15:0]              r_addr;
    logic [15:0]              r_wdata;
    logic [15:0]              r_rdata;
    logic [IO_BITS-1:0]       r_tx;
    logic                     r_busy;
    logic                     r_err;
    logic                     r_commit;

    state_t                   w_next_state;
    logic [15:0]              w_cnt_next;
    logic [IO_BITS-1:0]       w_tx_next;
    logic                     w_err_set;
    logic                     w_commit_next;
    logic                     w_shift_addr;
    logic                     w_shift_wdata;
    logic                     w_capture;
    logic                     w_shift_rdata;
    logic [15:0]              w_full_addr;
    logic [15:0]              w_data_last;
    logic [15:0]              w_ram_rdata;
    logic [15:0]              w_capture_word;
    logic                     w_ram_we;
    logic [1:0]               w_ram_be;
    logic [MEM_ADDR_BITS-1:0] w_ram_waddr;
    logic [15:0]              w_ram_wdata;
    logic                     w_unused_addr_bits;

    // Address as it will look once the current rx chunk is shifted in; on the
    // last address cycle this is the complete byte address used for capture.
    assign w_full_addr = {bus.rx_pins, r_addr[15:IO_BITS]};
    assign w_unused_addr_bits = ^w_full_addr[15:MEM_ADDR_BITS+1];
    assign w_data_last = cmd_is_byte(r_cmd) ? HALF_LAST : FULL_LAST;

    responder_mem #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_full_addr[MEM_ADDR_BITS:1]),
        .o_rdata (w_ram_rdata)
    );

    // RAM write port: a pending command commit takes priority over the backdoor.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_be    = 2'b00;
        w_ram_waddr = {MEM_ADDR_BITS{1'b0}};
        w_ram_wdata = 16'h0000;
        if (r_commit) begin
            w_ram_we    = 1'b1;
            w_ram_be    = byte_enables(cmd_is_byte(r_cmd), r_addr[0]);
            w_ram_waddr = r_addr[MEM_ADDR_BITS:1];
            // An 8-bit write's byte ends up in the top of the shift register.
            w_ram_wdata = cmd_is_byte(r_cmd) ? {r_wdata[15:8], r_wdata[15:8]} : r_wdata;
        end else if (bus.init_we) begin
            w_ram_we    = 1'b1;
            w_ram_be    = 2'b11;
            w_ram_waddr = bus.init_addr;
            w_ram_wdata = bus.init_data;
        end else begin
            w_ram_we    = 1'b0;
        end
    end

    // Read word selection: byte reads return the addressed byte in the low bits.
    always_comb begin
        w_capture_word = w_ram_rdata;
        if (cmd_is_byte(r_cmd)) begin
            w_capture_word = w_full_addr[0] ? {8'h00, w_ram_rdata[15:8]}
                                            : {8'h00, w_ram_rdata[7:0]};
        end else begin
            w_capture_word = w_ram_rdata;
        end
    end

    // Next-state, counter and next tx value for the frame FSM.
    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_tx_next     = IDLE_PAT;
        w_err_set     = 1'b0;
        w_commit_next = 1'b0;
        w_shift_addr  = 1'b0;
        w_shift_wdata = 1'b0;
        w_capture     = 1'b0;
        w_shift_rdata = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = 16'd0;
                if (bus.rx_pins != IDLE_PAT) begin
                    w_next_state = ST_HEADER;
                    // A malformed start is flagged but the frame still runs.
                    w_err_set    = (bus.rx_pins != START_PAT);
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HEADER: begin
                w_next_state = ST_ADDR;
                w_cnt_next   = 16'd0;
            end
            ST_ADDR: begin
                w_shift_addr = 1'b1;
                if (r_cnt == FULL_LAST) begin
                    w_cnt_next = 16'd0;
                    if (cmd_is_write(r_cmd)) begin
                        w_next_state = ST_WDATA;
                    end else begin
                        w_capture = 1'b1;
                        if (RESP_DELAY == 0) begin
                            w_next_state = ST_RSTART;
                            w_tx_next    = START_PAT;
                        end else begin
                            w_next_state = ST_DELAY;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_WDATA: begin
                w_shift_wdata = 1'b1;
                if (r_cnt == w_data_last) begin
                    w_next_state  = ST_IDLE;
                    w_cnt_next    = 16'd0;
                    w_commit_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_DELAY: begin
                w_err_set = (bus.rx_pins != IDLE_PAT);
                if (r_cnt == DLY_LAST) begin
                    w_next_state = ST_RSTART;
                    w_cnt_next   = 16'd0;
                    w_tx_next    = START_PAT;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_RSTART: begin
                w_err_set     = (bus.rx_pins != IDLE_PAT);
                w_next_state  = ST_RDATA;
                w_cnt_next    = 16'd0;
                w_tx_next     = r_rdata[IO_BITS-1:0];
                w_shift_rdata = 1'b1;
            end
            ST_RDATA: begin
                // r_cnt indexes the chunk currently on tx_pins.
                w_err_set = (bus.rx_pins != IDLE_PAT);
                if (r_cnt == w_data_last) begin
                    w_next_state = ST_IDLE;
                    w_cnt_next   = 16'd0;
                    w_tx_next    = IDLE_PAT;
                end else begin
                    w_cnt_next    = r_cnt + 16'd1;
                    w_tx_next     = r_rdata[IO_BITS-1:0];
                    w_shift_rdata = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    // State, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 16'd0;
            r_cmd    <= {TX_CMD_BITS{1'b0}};
            r_addr   <= 16'h0000;
            r_wdata  <= 16'h0000;
            r_rdata  <= 16'h0000;
            r_tx     <= IDLE_PAT;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_commit <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_next;
            r_tx     <= w_tx_next;
            // Busy also covers the commit cycle that follows a write frame.
            r_busy   <= (w_next_state != ST_IDLE) || w_commit_next;
            r_err    <= r_err | w_err_set;
            r_commit <= w_commit_next;
            if (r_state == ST_HEADER) begin
                r_cmd <= bus.rx_pins[TX_CMD_BITS-1:0];
            end
            if (w_shift_addr) begin
                r_addr <= w_full_addr;
            end
            if (w_shift_wdata) begin
                r_wdata <= {bus.rx_pins, r_wdata[15:IO_BITS]};
            end
            if (w_capture) begin
                r_rdata <= w_capture_word;
            end else if (w_shift_rdata) begin
                r_rdata <= {{IO_BITS{1'b0}}, r_rdata[15:IO_BITS]};
            end
        end
    end

    assign bus.tx_pins   = r_tx;
    assign bus.busy      = r_busy;
    assign bus.proto_err = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed, table-driven bench for mem_responder (IO_BITS=2,
// PAYLOAD_CYCLES=8, MEM_ADDR_BITS=6, RESP_DELAY=1). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int IOB = 2;
    localparam int PC  = 8;
    localparam int MAB = 6;
    localparam int RD  = 1;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] addr;
        logic [15:0] data;   // write data, or expected read data
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t tbl [14];

    always #5 clk = ~clk;

    mem_responder_if #(.IO_BITS(IOB), .MEM_ADDR_BITS(MAB)) bus ();

    mem_responder #(
        .IO_BITS        (IOB),
        .PAYLOAD_CYCLES (PC),
        .MEM_ADDR_BITS  (MAB),
        .RESP_DELAY     (RD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present v on rx_pins for one clock edge, return at the next falling edge.
    task automatic step(input logic [1:0] v);
        bus.rx_pins = v;
        @(negedge clk);
    endtask

    task automatic backdoor(input logic [5:0] a, input logic [15:0] d);
        bus.init_we   = 1'b1;
        bus.init_addr = a;
        bus.init_data = d;
        step(2'b00);
        bus.init_we   = 1'b0;
    endtask

    // Send a full command frame. Returns in the cycle after the last
    // address cycle (reads) or in the commit cycle (writes).
    task automatic send_cmd(input logic [1:0] cmd, input logic [15:0] addr,
                            input logic [15:0] data, input logic [1:0] start);
        int nw;
        step(start);
        chk("busy_rise", {31'd0, bus.busy}, 32'd1);
        step(cmd);
        for (int i = 0; i < PC; i++) step(addr[2*i +: 2]);
        if (cmd_is_write(cmd)) begin
            nw = cmd_is_byte(cmd) ? PC / 2 : PC;
            for (int i = 0; i < nw; i++) step(data[2*i +: 2]);
            chk("busy_commit", {31'd0, bus.busy}, 32'd1);
        end
        bus.rx_pins = 2'b00;
    endtask

    // Check the response frame; rx_pins gets inj_val on data step inj_at.
    task automatic expect_read(input logic [15:0] exp, input logic is8,
                               input int inj_at, input logic [1:0] inj_val);
        int n;
        for (int d = 0; d < RD; d++) begin
            chk("delay_tx", {30'd0, bus.tx_pins}, 32'd0);
            step(2'b00);
        end
        chk("start_tx", {30'd0, bus.tx_pins}, 32'd1);
        n = is8 ? PC / 2 : PC;
        for (int i = 0; i < n; i++) begin
            step((i == inj_at) ? inj_val : 2'b00);
            chk($sformatf("data_tx[%0d]@%0h", i, exp), {30'd0, bus.tx_pins}, {30'd0, exp[2*i +: 2]});
        end
        step(2'b00);
        chk("end_tx", {30'd0, bus.tx_pins}, 32'd0);
        chk("end_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{TX_HEADER_READ_16,  16'h000A, 16'hBEEF};
        tbl[1]  = '{TX_HEADER_WRITE_16, 16'h0002, 16'h1234};
        tbl[2]  = '{TX_HEADER_READ_16,  16'h0003, 16'h1234};
        tbl[3]  = '{TX_HEADER_WRITE_16, 16'h0002, 16'hFFFF};
        tbl[4]  = '{TX_HEADER_WRITE_8,  16'h0003, 16'h005A};
        tbl[5]  = '{TX_HEADER_READ_16,  16'h0002, 16'h5AFF};
        tbl[6]  = '{TX_HEADER_READ_8,   16'h0002, 16'h00FF};
        tbl[7]  = '{TX_HEADER_READ_8,   16'h0003, 16'h005A};
        tbl[8]  = '{TX_HEADER_READ_16,  16'hFF80, 16'hC3A5};
        tbl[9]  = '{TX_HEADER_WRITE_8,  16'h0080, 16'h0011};
        tbl[10] = '{TX_HEADER_READ_16,  16'h0081, 16'hC311};
        tbl[11] = '{TX_HEADER_WRITE_16, 16'h007E, 16'hABCD};
        tbl[12] = '{TX_HEADER_READ_8,   16'h007F, 16'h00AB};
        tbl[13] = '{TX_HEADER_READ_8,   16'hFFFE, 16'h00CD};

        reset         = 1'b1;
        bus.rx_pins   = 2'b00;
        bus.init_we   = 1'b0;
        bus.init_addr = 6'd0;
        bus.init_data = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_tx",   {30'd0, bus.tx_pins},   32'd0);
        chk("rst_busy", {31'd0, bus.busy},      32'd0);
        chk("rst_err",  {31'd0, bus.proto_err}, 32'd0);
        reset = 1'b0;
        step(2'b00);

        backdoor(6'd5, 16'hBEEF);
        backdoor(6'd0, 16'hC3A5);

        // Table: writes flow straight into the next start.
        for (int k = 0; k < 14; k++) begin
            send_cmd(tbl[k].cmd, tbl[k].addr, tbl[k].data, 2'b01);
            if (!cmd_is_write(tbl[k].cmd)) begin
                expect_read(tbl[k].data, cmd_is_byte(tbl[k].cmd), -1, 2'b00);
            end
        end
        chk("tbl_err", {31'd0, bus.proto_err}, 32'd0);

        // Isolated write: busy drops the cycle after the commit.
        send_cmd(TX_HEADER_WRITE_16, 16'h0010, 16'h7777, 2'b01);
        step(2'b00);
        chk("wr_busy_fall", {31'd0, bus.busy}, 32'd0);
        send_cmd(TX_HEADER_READ_16, 16'h0010, 16'h0000, 2'b01);
        expect_read(16'h7777, 1'b0, -1, 2'b00);

        // Noise on rx during RDATA: data intact, error sticky.
        send_cmd(TX_HEADER_READ_16, 16'h000A, 16'h0000, 2'b01);
        expect_read(16'hBEEF, 1'b0, 3, 2'b10);
        chk("inj_err", {31'd0, bus.proto_err}, 32'd1);
        repeat (3) step(2'b00);
        chk("inj_err_sticky", {31'd0, bus.proto_err}, 32'd1);

        // Reset in the middle of the address field.
        step(2'b01);
        step(TX_HEADER_READ_16);
        step(2'b10);
        step(2'b01);
        step(2'b11);
        reset       = 1'b1;
        bus.rx_pins = 2'b00;
        @(negedge clk);
        chk("mid_rst_tx",   {30'd0, bus.tx_pins},   32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy},      32'd0);
        chk("mid_rst_err",  {31'd0, bus.proto_err}, 32'd0);
        reset = 1'b0;
        step(2'b00);
        send_cmd(TX_HEADER_READ_16, 16'h000A, 16'h0000, 2'b01);
        expect_read(16'hBEEF, 1'b0, -1, 2'b00);
        chk("post_rst_err", {31'd0, bus.proto_err}, 32'd0);

        // Malformed start pattern: flagged, frame still executed.
        send_cmd(TX_HEADER_READ_16, 16'h000A, 16'h0000, 2'b11);
        chk("bad_start_err", {31'd0, bus.proto_err}, 32'd1);
        expect_read(16'hBEEF, 1'b0, -1, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
